song_sequencer: RTL and testbench

Playback scheduler for auto mode. It latches a song number and steps through the song ROM one entry at a time. Each note is held on `note_out`/`octave_out` for its encoded duration, followed by a fixed silent gap. It supports start/restart, pause/resume and end-of-song detection, and drives the buzzer datapath and key LEDs in place of the free-running auto-mode logic.

---
 rtl/song_sequencer_pkg.sv | 33 +++
 rtl/song_sequencer_if.sv | 10 +
 rtl/song_sequencer_tick_gen.sv | 24 ++
 rtl/song_sequencer.sv | 157 +++++++++++++++
 tb/tb_song_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/song_sequencer_pkg.sv
// Shared types, constants and helpers for the auto-mode song sequencer.
package song_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [3:0] NOTE_REST = 4'h0;
    localparam logic [3:0] NOTE_END  = 4'hF;

    localparam int unsigned NOTE_MSB = 9;
    localparam int unsigned NOTE_LSB = 6;
    localparam int unsigned OCT_MSB  = 5;
    localparam int unsigned OCT_LSB  = 4;
    localparam int unsigned DUR_MSB  = 3;
    localparam int unsigned DUR_LSB  = 0;

    // Notes 1..7 light LED bit note-1; everything else leaves the LEDs dark.
    function automatic logic [6:0] note_to_led(input logic [3:0] note);
        logic [6:0] led;
        led = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            led[i] = (note == 4'(i + 1));
        end
        return led;
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Song ROM bus: the sequencer drives the address, the ROM returns data one cycle later.
interface song_sequencer_if #(
    parameter int unsigned IDX_W = 6
);
    logic [IDX_W+1:0] rom_addr;
    logic [9:0]       rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/song_sequencer_tick_gen.sv
// Duration prescaler: one-cycle tick every TICK_CYC enabled clocks, frozen when not enabled.
module tick_gen #(
    parameter int unsigned TICK_CYC = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int unsigned W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    logic [W-1:0] cnt;

    assign tick = enable && (cnt == W'(TICK_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/song_sequencer.sv
// Auto-mode playback scheduler: walks one song of the ROM, holding each note for its
// encoded duration followed by a silent gap, with pause/restart and end-of-song handling.
module song_sequencer
    import song_seq_pkg::*;
#(
    parameter int unsigned TICK_CYC = 12_500_000,
    parameter int unsigned GAP_CYC  = 2_500_000,
    parameter int unsigned SONG_LEN = 64,
    parameter int unsigned IDX_W    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic [1:0]        song_select,
    song_sequencer_if.master  rom,
    output logic [3:0]        note_out,
    output logic [1:0]        octave_out,
    output logic [6:0]        led_out,
    output logic [3:0]        num,
    output logic              playing,
    output logic              done
);
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t             state, state_nx;
    logic [1:0]         song, song_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [3:0]         note_r, note_nx;
    logic [1:0]         oct_r, oct_nx;
    logic [3:0]         dur_cnt, dur_nx;
    logic [GAP_W-1:0]   gap_cnt, gap_nx;
    logic               done_nx;
    logic               presc_clear, presc_en, tick;
    logic               show_nx;

    logic [3:0] rd_note;
    logic [1:0] rd_oct;
    logic [3:0] rd_dur;

    assign rd_note = rom.rom_data[NOTE_MSB:NOTE_LSB];
    assign rd_oct  = rom.rom_data[OCT_MSB:OCT_LSB];
    assign rd_dur  = rom.rom_data[DUR_MSB:DUR_LSB];

    tick_gen #(.TICK_CYC(TICK_CYC)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (presc_clear),
        .enable (presc_en),
        .tick   (tick)
    );

    always_comb begin
        state_nx    = state;
        song_nx     = song;
        idx_nx      = idx;
        note_nx     = note_r;
        oct_nx      = oct_r;
        dur_nx      = dur_cnt;
        gap_nx      = gap_cnt;
        done_nx     = 1'b0;
        presc_clear = 1'b0;
        presc_en    = 1'b0;

        if (start) begin
            song_nx     = song_select;
            idx_nx      = '0;
            state_nx    = S_FETCH;
            presc_clear = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: ;
                S_FETCH: state_nx = S_LOAD;
                S_LOAD: begin
                    if (rd_note == NOTE_END) begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                    end else begin
                        // Notes above ti are held for their duration but never sounded.
                        note_nx     = (rd_note >= 4'd8) ? NOTE_REST : rd_note;
                        oct_nx      = rd_oct;
                        dur_nx      = (rd_dur == 4'd0) ? 4'd1 : rd_dur;
                        presc_clear = 1'b1;
                        state_nx    = S_PLAY;
                    end
                end
                S_PLAY: begin
                    presc_en = !pause;
                    if (tick) begin
                        if (dur_cnt <= 4'd1) begin
                            state_nx    = S_GAP;
                            gap_nx      = '0;
                            presc_clear = 1'b1;
                        end else begin
                            dur_nx = dur_cnt - 4'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (!pause) begin
                        if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                            if (idx == IDX_W'(SONG_LEN - 1)) begin
                                state_nx = S_DONE;
                                done_nx  = 1'b1;
                            end else begin
                                idx_nx   = idx + 1'b1;
                                state_nx = S_FETCH;
                            end
                        end else begin
                            gap_nx = gap_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end

        show_nx = (state_nx == S_PLAY) && !pause;
    end

    // Outputs are computed from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            song         <= '0;
            idx          <= '0;
            note_r       <= '0;
            oct_r        <= '0;
            dur_cnt      <= '0;
            gap_cnt      <= '0;
            note_out     <= '0;
            octave_out   <= '0;
            led_out      <= '0;
            num          <= '0;
            playing      <= 1'b0;
            done         <= 1'b0;
            rom.rom_addr <= '0;
        end else begin
            state        <= state_nx;
            song         <= song_nx;
            idx          <= idx_nx;
            note_r       <= note_nx;
            oct_r        <= oct_nx;
            dur_cnt      <= dur_nx;
            gap_cnt      <= gap_nx;
            note_out     <= show_nx ? note_nx : NOTE_REST;
            octave_out   <= (state_nx == S_PLAY) ? oct_nx : '0;
            led_out      <= show_nx ? note_to_led(note_nx) : '0;
            num          <= (state_nx == S_IDLE) ? '0 : {2'b00, song_nx} + 4'd1;
            playing      <= (state_nx == S_FETCH) || (state_nx == S_LOAD) ||
                            (state_nx == S_PLAY)  || (state_nx == S_GAP);
            done         <= done_nx;
            rom.rom_addr <= {song_nx, idx_nx};
        end
    end
endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a small behavioural song ROM.
module tb_song_sequencer;
    logic       clk;
    logic       reset;
    logic       start;
    logic       pause;
    logic [1:0] song_select;
    logic [3:0] note_out;
    logic [1:0] octave_out;
    logic [6:0] led_out;
    logic [3:0] num;
    logic       playing;
    logic       done;

    int checks   = 0;
    int failures = 0;

    logic [9:0] rom_mem [0:31];
    logic [3:0] exp_note;
    logic [6:0] exp_led;
    int         done_cnt;

    song_sequencer_if #(.IDX_W(3)) rom_bus ();

    song_sequencer #(
        .TICK_CYC (4),
        .GAP_CYC  (2),
        .SONG_LEN (8),
        .IDX_W    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .song_select (song_select),
        .rom         (rom_bus),
        .note_out    (note_out),
        .octave_out  (octave_out),
        .led_out     (led_out),
        .num         (num),
        .playing     (playing),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_bus.rom_data <= rom_mem[rom_bus.rom_addr];

    task automatic go_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom_mem[i] = 10'h3C0;
        // song 0: dur-0 note, silent note 9, note 4, end
        rom_mem[0]  = {4'd2, 2'd1, 4'd0};
        rom_mem[1]  = {4'd9, 2'd0, 4'd1};
        rom_mem[2]  = {4'd4, 2'd0, 4'd1};
        // song 1
        rom_mem[8]  = {4'd3, 2'd1, 4'd2};
        rom_mem[9]  = {4'd5, 2'd2, 4'd1};
        // song 2
        rom_mem[16] = {4'd7, 2'd3, 4'd1};
        // song 3: full song without end marker
        for (int i = 24; i < 32; i++) rom_mem[i] = {4'd1, 2'd0, 4'd1};

        reset = 1'b1; start = 1'b0; pause = 1'b0; song_select = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_note", 0, note_out, 0);
        chk("rst_oct", 0, octave_out, 0);
        chk("rst_led", 0, led_out, 0);
        chk("rst_num", 0, num, 0);
        chk("rst_playing", 0, playing, 0);
        chk("rst_done", 0, done, 0);
        chk("rst_addr", 0, rom_bus.rom_addr, 0);
        reset = 1'b0;
        go_edge();
        chk("idle_playing", 0, playing, 0);

        // Scenario 1: basic playback of song 1
        start = 1'b1; song_select = 2'd1;
        for (int c = 1; c <= 24; c++) begin
            go_edge();
            start = 1'b0;
            exp_note = (c >= 3 && c <= 10) ? 4'd3 : (c >= 15 && c <= 18) ? 4'd5 : 4'd0;
            exp_led  = (exp_note == 4'd3) ? 7'b0000100 : (exp_note == 4'd5) ? 7'b0010000 : 7'b0;
            chk("s1_note", c, note_out, exp_note);
            chk("s1_led", c, led_out, exp_led);
            chk("s1_num", c, num, (c <= 23) ? 2 : 0);
            chk("s1_done", c, done, (c == 23) ? 1 : 0);
            chk("s1_playing", c, playing, (c <= 22) ? 1 : 0);
            if (c == 1) chk("s1_addr", c, rom_bus.rom_addr, 8);
            if (c == 3) chk("s1_oct", c, octave_out, 1);
            if (c == 15) chk("s1_oct2", c, octave_out, 2);
        end

        // Scenario 2: pause held for five cycles mid-note
        start = 1'b1; song_select = 2'd1;
        for (int c = 1; c <= 29; c++) begin
            go_edge();
            start = 1'b0;
            pause = (c >= 5 && c <= 9);
            exp_note = ((c >= 3 && c <= 5) || (c >= 11 && c <= 15)) ? 4'd3 :
                       (c >= 20 && c <= 23) ? 4'd5 : 4'd0;
            chk("s2_note", c, note_out, exp_note);
            chk("s2_led", c, led_out, (exp_note == 4'd3) ? 7'b0000100 :
                                      (exp_note == 4'd5) ? 7'b0010000 : 7'b0);
            chk("s2_playing", c, playing, (c <= 27) ? 1 : 0);
            chk("s2_done", c, done, (c == 28) ? 1 : 0);
        end

        // Scenario 3: restart into song 2, later song_select change ignored
        start = 1'b1; song_select = 2'd1;
        for (int c = 1; c <= 19; c++) begin
            go_edge();
            start = (c == 7);
            if (c == 7) song_select = 2'd2;
            if (c == 9) song_select = 2'd3;
            exp_note = (c >= 3 && c <= 7) ? 4'd3 : (c >= 10 && c <= 13) ? 4'd7 : 4'd0;
            chk("s3_note", c, note_out, exp_note);
            chk("s3_done", c, done, (c == 18) ? 1 : 0);
            if (c == 7)  chk("s3_num_old", c, num, 2);
            if (c == 8)  chk("s3_addr0", c, rom_bus.rom_addr, 16);
            if (c == 8)  chk("s3_num_new", c, num, 3);
            if (c == 10) chk("s3_oct", c, octave_out, 3);
            if (c == 10) chk("s3_led", c, led_out, 7'b1000000);
            if (c == 16) chk("s3_addr1", c, rom_bus.rom_addr, 17);
            if (c == 16) chk("s3_num_hold", c, num, 3);
            if (c == 19) chk("s3_idle", c, playing, 0);
        end

        // Scenario 4: eight entries without end marker
        start = 1'b1; song_select = 2'd3;
        done_cnt = 0;
        for (int c = 1; c <= 70; c++) begin
            go_edge();
            start = 1'b0;
            if (done === 1'b1) done_cnt++;
            exp_note = (c >= 3 && c <= 62 && ((c - 3) % 8) < 4) ? 4'd1 : 4'd0;
            chk("s4_note", c, note_out, exp_note);
            chk("s4_playing", c, playing, (c <= 64) ? 1 : 0);
            if (c == 59) chk("s4_led", c, led_out, 7'b0000001);
            if (c == 57) chk("s4_addr7", c, rom_bus.rom_addr, 31);
            if (c == 65) chk("s4_done", c, done, 1);
            if (c == 65 || c == 70) chk("s4_nowrap", c, rom_bus.rom_addr, 31);
            if (c == 70) chk("s4_num_idle", c, num, 0);
        end
        chk("s4_done_count", 70, done_cnt, 1);

        // Scenario 5a: dur 0 plays one tick, note 9 plays silent
        start = 1'b1; song_select = 2'd0;
        for (int c = 1; c <= 28; c++) begin
            go_edge();
            start = 1'b0;
            exp_note = (c >= 3 && c <= 6) ? 4'd2 : (c >= 19 && c <= 22) ? 4'd4 : 4'd0;
            chk("s5_note", c, note_out, exp_note);
            chk("s5_playing", c, playing, (c <= 26) ? 1 : 0);
            chk("s5_done", c, done, (c == 27) ? 1 : 0);
            if (c >= 11 && c <= 14) chk("s5_rest_led", c, led_out, 0);
            if (c == 3) chk("s5_oct", c, octave_out, 1);
            if (c == 3) chk("s5_led", c, led_out, 7'b0000010);
        end

        // Scenario 5b: reset during PLAY
        start = 1'b1; song_select = 2'd0;
        for (int c = 1; c <= 7; c++) begin
            go_edge();
            start = 1'b0;
            reset = (c == 4);
            if (c == 4) chk("s5r_note_pre", c, note_out, 2);
            if (c == 5) begin
                chk("s5r_note", c, note_out, 0);
                chk("s5r_oct", c, octave_out, 0);
                chk("s5r_led", c, led_out, 0);
                chk("s5r_num", c, num, 0);
                chk("s5r_playing", c, playing, 0);
                chk("s5r_done", c, done, 0);
                chk("s5r_addr", c, rom_bus.rom_addr, 0);
            end
            if (c >= 6) chk("s5r_idle_playing", c, playing, 0);
            if (c >= 6) chk("s5r_idle_note", c, note_out, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
